// File: rtl/quad_cnt_pkg.sv
// Shared register map, control/status bit positions and quadrature decode helpers
// for the multi-channel quadrature step counter.
package quad_cnt_pkg;

    localparam logic [3:0] OFF_CNT0   = 4'h0;
    localparam logic [3:0] OFF_CNT1   = 4'h1;
    localparam logic [3:0] OFF_CNT2   = 4'h2;
    localparam logic [3:0] OFF_CNT3   = 4'h3;
    localparam logic [3:0] OFF_LIM0   = 4'h4;
    localparam logic [3:0] OFF_LIM1   = 4'h5;
    localparam logic [3:0] OFF_LIM2   = 4'h6;
    localparam logic [3:0] OFF_LIM3   = 4'h7;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'h9;

    localparam int CH_STRIDE = 16;

    localparam int EN     = 0;
    localparam int IRQ_EN = 1;
    localparam int WRAP   = 2;
    localparam int CLR    = 3;

    localparam int DONE = 0;
    localparam int ERR  = 1;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN,
        STEP_ILLEGAL
    } step_e;

    // Position of a {A,B} state along the up sequence 00->01->11->10.
    function automatic logic [1:0] gray_pos(input logic [1:0] s);
        return {s[1], s[1] ^ s[0]};
    endfunction

    function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] d;
        d = gray_pos(cur) - gray_pos(prev);
        case (d)
            2'd0:    return STEP_NONE;
            2'd1:    return STEP_UP;
            2'd3:    return STEP_DOWN;
            default: return STEP_ILLEGAL;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] v, input logic [1:0] idx);
        return v[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/quad_step_counter_multi_channel.sv
// One encoder channel: synchroniser, glitch filter, step decode, counter,
// limit/done/err flags, CTRL/STATUS registers and the count snapshot.
module quad_channel
    import quad_cnt_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       sel,
    input  logic       rd_en,
    input  logic       wr_en,
    input  logic [3:0] off,
    input  logic [7:0] wdata,
    output logic [7:0] rd_byte,
    output logic       irq_req
);
    localparam int NB = CNT_W / 8;

    logic [1:0]       sync1, sync2, cand, filt, filt_prev;
    logic [3:0]       run, run_next;
    logic [CNT_W-1:0] count, limit, shadow;
    logic             en, irq_en, wrap, done, err;
    logic             clr, w1c_done, w1c_err, done_set, err_set;
    step_e            step;

    assign run_next = (sync2 != cand)          ? 4'd1 :
                      (run < 4'(FILT_LEN))     ? run + 4'd1 : run;
    assign step     = decode_step(filt_prev, filt);
    assign clr      = wr_en && (off == OFF_CTRL) && wdata[CLR];
    assign w1c_done = wr_en && (off == OFF_STATUS) && wdata[DONE];
    assign w1c_err  = wr_en && (off == OFF_STATUS) && wdata[ERR];
    assign done_set = (limit != '0) && (count >= limit);
    assign err_set  = (step == STEP_ILLEGAL);
    assign irq_req  = irq_en & (done | err);

    // The filtered state only follows a synchronised value that has been seen for FILT_LEN cycles in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 2'b00;
            sync2     <= 2'b00;
            cand      <= 2'b00;
            run       <= 4'd0;
            filt      <= 2'b00;
            filt_prev <= 2'b00;
        end else begin
            sync1     <= {enc_a, enc_b};
            sync2     <= sync1;
            cand      <= sync2;
            run       <= run_next;
            if (run_next >= 4'(FILT_LEN))
                filt <= sync2;
            filt_prev <= filt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !done) begin
            case (step)
                STEP_UP:   if (wrap || count != '1) count <= count + CNT_W'(1);
                STEP_DOWN: if (wrap || count != '0) count <= count - CNT_W'(1);
                default:   ;
            endcase
        end
    end

    // A new set condition beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en     <= 1'b0;
            irq_en <= 1'b0;
            wrap   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            limit  <= '0;
            shadow <= '0;
        end else begin
            if (wr_en && off == OFF_CTRL) begin
                en     <= wdata[EN];
                irq_en <= wdata[IRQ_EN];
                wrap   <= wdata[WRAP];
            end
            done <= done_set | (done & ~w1c_done);
            err  <= err_set | (err & ~w1c_err);
            for (int k = 0; k < NB; k++) begin
                if (wr_en && off == OFF_LIM0 + 4'(k))
                    limit[8*k +: 8] <= wdata;
            end
            if (clr)
                shadow <= '0;
            else if (rd_en && off == OFF_CNT0)
                shadow <= count;
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        if (sel) begin
            case (off)
                OFF_CNT0:                     rd_byte = count[7:0];
                OFF_CNT1, OFF_CNT2, OFF_CNT3: rd_byte = byte_of(32'(shadow), off[1:0]);
                OFF_LIM0, OFF_LIM1,
                OFF_LIM2, OFF_LIM3:           rd_byte = byte_of(32'(limit), off[1:0]);
                OFF_CTRL:                     rd_byte = {5'b0, wrap, irq_en, en};
                OFF_STATUS:                   rd_byte = {6'b0, err, done};
                default:                      rd_byte = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/quad_step_counter_multi.sv
// Multi-channel quadrature step counter: bus address decode, registered read
// data and the combined interrupt over all channels.
module quad_step_counter_multi
    import quad_cnt_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              cs,
    input  logic              rd,
    input  logic              wr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    input  logic [N_CH-1:0]   enc_a,
    input  logic [N_CH-1:0]   enc_b,
    output logic              irq
);
    localparam int CH_W = ADDR_W - 4;

    logic [CH_W-1:0] ch_idx;
    logic [3:0]      off;
    logic            rd_req, wr_req;
    logic [7:0]      ch_byte [N_CH];
    logic [N_CH-1:0] ch_irq;
    logic [7:0]      rd_mux;

    assign ch_idx = addr[ADDR_W-1:4];
    assign off    = addr[3:0];
    // A combined read+write is treated as a write only, so it has no read side effects.
    assign rd_req = cs & rd & ~wr;
    assign wr_req = cs & wr;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic sel;
        assign sel = cs && (ch_idx == CH_W'(i));

        quad_channel #(
            .CNT_W    (CNT_W),
            .FILT_LEN (FILT_LEN)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .enc_a   (enc_a[i]),
            .enc_b   (enc_b[i]),
            .sel     (sel),
            .rd_en   (rd_req & sel),
            .wr_en   (wr_req & sel),
            .off     (off),
            .wdata   (wdata),
            .rd_byte (ch_byte[i]),
            .irq_req (ch_irq[i])
        );
    end

    // Unselected channels drive zero, so an OR is enough; out-of-range channels read 0x00.
    always_comb begin
        rd_mux = 8'h00;
        for (int i = 0; i < N_CH; i++)
            rd_mux = rd_mux | ch_byte[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'h00;
            irq   <= 1'b0;
        end else begin
            rdata <= rd_req ? rd_mux : 8'h00;
            irq   <= |ch_irq;
        end
    end

endmodule

// File: tb/tb_quad_step_counter_multi.sv
// Self-checking bench for quad_step_counter_multi: directed scenarios plus a
// randomized step walk compared against a position/count reference model.
module tb_quad_step_counter_multi;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr;
    logic       cs, rd, wr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [1:0] enc_a, enc_b;
    logic       irq;

    int tests_run;
    int tests_failed;

    int m_count [2];
    int m_limit [2];
    bit m_en [2], m_irq_en [2], m_wrap [2], m_done [2], m_err [2];
    int pos [2];

    quad_step_counter_multi dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .cs    (cs),
        .rd    (rd),
        .wr    (wr),
        .wdata (wdata),
        .rdata (rdata),
        .enc_a (enc_a),
        .enc_b (enc_b),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [1:0] gray_of(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_count[c] = 0; m_limit[c] = 0; m_en[c] = 0; m_irq_en[c] = 0;
            m_wrap[c] = 0; m_done[c] = 0; m_err[c] = 0; pos[c] = 0;
        end
    endfunction

    function automatic void model_eval_done(input int ch);
        if (m_limit[ch] != 0 && m_count[ch] >= m_limit[ch]) m_done[ch] = 1'b1;
    endfunction

    function automatic void model_apply(input int ch, input int delta);
        int nv;
        if (delta == 2) begin
            m_err[ch] = 1'b1;
        end else if (m_en[ch] && !m_done[ch]) begin
            nv = m_count[ch] + delta;
            if (m_wrap[ch]) nv = nv & 32'h0000FFFF;
            else if (nv < 0) nv = 0;
            else if (nv > 65535) nv = 65535;
            m_count[ch] = nv;
        end
        model_eval_done(ch);
    endfunction

    function automatic logic exp_irq();
        logic r;
        r = 1'b0;
        for (int c = 0; c < 2; c++) r = r | (m_irq_en[c] & (m_done[c] | m_err[c]));
        return r;
    endfunction

    function automatic logic [7:0] exp_status(input int ch);
        return {6'b0, m_err[ch], m_done[ch]};
    endfunction

    // ---------------- stimulus helpers (all start and end on a negedge) ----------------
    task automatic drive_enc(input int ch);
        logic [1:0] g;
        g = gray_of(pos[ch]);
        enc_a[ch] = g[1];
        enc_b[ch] = g[0];
    endtask

    task automatic move(input int ch, input int delta, input int hold);
        pos[ch] = (pos[ch] + delta) & 3;
        drive_enc(ch);
        repeat (hold) @(negedge clk);
        model_apply(ch, delta);
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    task automatic bus_write(input int ch, input logic [3:0] off, input logic [7:0] d);
        addr = {4'(ch), off}; wdata = d; cs = 1'b1; wr = 1'b1;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input int ch, input logic [3:0] off, output logic [7:0] d);
        addr = {4'(ch), off}; cs = 1'b1; rd = 1'b1;
        @(posedge clk);
        #1 d = rdata;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic read_cnt(input int ch, output logic [15:0] v);
        logic [7:0] lo, hi;
        bus_read(ch, 4'h0, lo);
        bus_read(ch, 4'h1, hi);
        v = {hi, lo};
    endtask

    task automatic wr_ctrl(input int ch, input logic [7:0] v);
        bus_write(ch, 4'h8, v);
        m_en[ch] = v[0]; m_irq_en[ch] = v[1]; m_wrap[ch] = v[2];
        if (v[3]) m_count[ch] = 0;
        model_eval_done(ch);
    endtask

    task automatic wr_limit(input int ch, input int lim);
        bus_write(ch, 4'h4, lim[7:0]);
        bus_write(ch, 4'h5, lim[15:8]);
        m_limit[ch] = lim & 32'h0000FFFF;
        model_eval_done(ch);
    endtask

    task automatic wr_status(input int ch, input logic [7:0] v);
        bus_write(ch, 4'h9, v);
        if (v[0]) m_done[ch] = 1'b0;
        if (v[1]) m_err[ch] = 1'b0;
        model_eval_done(ch);
    endtask

    // Continuous reads of ch0 CNT0 while a raw pulse of 'width' clocks is applied.
    task automatic glitch_pulse(input int width, output int mx, output logic [7:0] last);
        int p0;
        p0 = pos[0];
        mx = 0;
        pos[0] = (p0 + 1) & 3; drive_enc(0);
        addr = 8'h00; cs = 1'b1; rd = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (int'(rdata) > mx) mx = int'(rdata);
            last = rdata;
            if (k == width) begin
                pos[0] = p0; drive_enc(0);
            end
        end
        cs = 1'b0; rd = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [3:0] offs [6];
        logic [7:0] d;
        offs = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h8, 4'h9};
        tests_run++;
        if (rdata !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h expected 00", rdata); end
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 6; i++) begin
                bus_read(c, offs[i], d);
                tests_run++;
                if (d !== 8'h00) begin
                    tests_failed++;
                    $display("[TB] FAIL reset_reg ch%0d off%h: got %h expected 00", c, offs[i], d);
                end
            end
        end
    endtask

    task automatic test_up_count();
        logic [7:0]  samp [8];
        logic [15:0] v;
        wr_ctrl(0, 8'h01);
        pos[0] = 1; drive_enc(0);
        addr = 8'h00; cs = 1'b1; rd = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1 samp[k] = rdata;
        end
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        model_apply(0, 1);
        tests_run++;
        if (samp[6] !== 8'h00) begin tests_failed++; $display("[TB] FAIL latency_early: got %h expected 00", samp[6]); end
        tests_run++;
        if (samp[7] !== 8'h01) begin tests_failed++; $display("[TB] FAIL latency_exact: got %h expected 01", samp[7]); end
        for (int s = 1; s < 32; s++) move(0, 1, 5);
        settle();
        read_cnt(0, v);
        tests_run++;
        if (v !== 16'h0020 || v !== 16'(m_count[0])) begin
            tests_failed++; $display("[TB] FAIL up_count: got %h expected 0020", v);
        end
    endtask

    task automatic test_glitch();
        int         mx;
        logic [7:0] last, d;
        logic [15:0] v;
        wr_ctrl(0, 8'h09);
        settle();
        glitch_pulse(2, mx, last);
        tests_run++;
        if (mx !== 0) begin tests_failed++; $display("[TB] FAIL glitch_2clk: got max %0d expected 0", mx); end
        glitch_pulse(3, mx, last);
        tests_run++;
        if (mx !== 1) begin tests_failed++; $display("[TB] FAIL pulse_3clk_step: got max %0d expected 1", mx); end
        tests_run++;
        if (last !== 8'h00) begin tests_failed++; $display("[TB] FAIL pulse_3clk_return: got %h expected 00", last); end
        bus_read(0, 4'h9, d);
        tests_run++;
        if (d !== 8'h00) begin tests_failed++; $display("[TB] FAIL glitch_err: got %h expected 00", d); end
        move(0, 1, 10);
        settle();
        read_cnt(0, v);
        tests_run++;
        if (v !== 16'(m_count[0])) begin tests_failed++; $display("[TB] FAIL stable_step: got %h expected %h", v, 16'(m_count[0])); end
    endtask

    task automatic test_sat_wrap();
        logic [15:0] v;
        wr_ctrl(0, 8'h09);
        move(0, -1, 5); move(0, -1, 5);
        settle();
        read_cnt(0, v);
        tests_run++;
        if (v !== 16'h0000) begin tests_failed++; $display("[TB] FAIL saturate_low: got %h expected 0000", v); end
        wr_ctrl(0, 8'h05);
        move(0, -1, 5); move(0, -1, 5);
        settle();
        read_cnt(0, v);
        tests_run++;
        if (v !== 16'hFFFE || v !== 16'(m_count[0])) begin tests_failed++; $display("[TB] FAIL wrap_low: got %h expected FFFE", v); end
    endtask

    task automatic test_limit_done();
        logic [15:0] v;
        logic [7:0]  d;
        wr_ctrl(0, 8'h0B);
        wr_limit(0, 5);
        for (int s = 0; s < 7; s++) move(0, 1, 5);
        settle();
        read_cnt(0, v);
        tests_run++;
        if (v !== 16'h0005) begin tests_failed++; $display("[TB] FAIL limit_stop: got %h expected 0005", v); end
        bus_read(0, 4'h9, d);
        tests_run++;
        if (d !== exp_status(0) || d !== 8'h01) begin tests_failed++; $display("[TB] FAIL done_set: got %h expected 01", d); end
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL done_irq: got %b expected 1", irq); end
        wr_limit(0, 0);
        wr_status(0, 8'h01);
        repeat (2) @(negedge clk);
        bus_read(0, 4'h9, d);
        tests_run++;
        if (d !== 8'h00) begin tests_failed++; $display("[TB] FAIL done_clear: got %h expected 00", d); end
        tests_run++;
        if (irq !== exp_irq()) begin tests_failed++; $display("[TB] FAIL irq_clear: got %b expected %b", irq, exp_irq()); end
        move(0, 1, 5);
        settle();
        read_cnt(0, v);
        tests_run++;
        if (v !== 16'h0006) begin tests_failed++; $display("[TB] FAIL count_resume: got %h expected 0006", v); end
        wr_limit(0, 5);
        wr_status(0, 8'h01);
        repeat (2) @(negedge clk);
        bus_read(0, 4'h9, d);
        tests_run++;
        if (d !== exp_status(0) || d !== 8'h01) begin tests_failed++; $display("[TB] FAIL done_reset_again: got %h expected 01", d); end
        wr_limit(0, 0);
        wr_status(0, 8'h03);
        wr_ctrl(0, 8'h01);
    endtask

    task automatic test_illegal_snapshot();
        logic [15:0] v;
        logic [7:0]  d;
        wr_ctrl(0, 8'h09);
        move(0, 2, 6);
        settle();
        bus_read(0, 4'h9, d);
        tests_run++;
        if (d !== 8'h02) begin tests_failed++; $display("[TB] FAIL illegal_err: got %h expected 02", d); end
        read_cnt(0, v);
        tests_run++;
        if (v !== 16'h0000) begin tests_failed++; $display("[TB] FAIL illegal_count: got %h expected 0000", v); end
        wr_status(0, 8'h02);
        for (int s = 0; s < 511; s++) move(0, 1, 4);
        settle();
        bus_read(0, 4'h0, d);
        tests_run++;
        if (d !== 8'hFF) begin tests_failed++; $display("[TB] FAIL snap_lsb: got %h expected FF", d); end
        move(0, 1, 4);
        settle();
        bus_read(0, 4'h1, d);
        tests_run++;
        if (d !== 8'h01) begin tests_failed++; $display("[TB] FAIL snap_shadow: got %h expected 01", d); end
        read_cnt(0, v);
        tests_run++;
        if (v !== 16'(m_count[0]) || v !== 16'h0200) begin tests_failed++; $display("[TB] FAIL snap_live: got %h expected 0200", v); end
    endtask

    task automatic test_isolation();
        logic [15:0] v;
        logic [7:0]  d;
        wr_ctrl(0, 8'h09);
        wr_ctrl(1, 8'h0D);
        for (int s = 0; s < 3; s++) move(1, -1, 5);
        for (int s = 0; s < 4; s++) move(1, 1, 5);
        settle();
        read_cnt(1, v);
        tests_run++;
        if (v !== 16'h0001 || v !== 16'(m_count[1])) begin tests_failed++; $display("[TB] FAIL iso_ch1: got %h expected 0001", v); end
        read_cnt(0, v);
        tests_run++;
        if (v !== 16'h0000) begin tests_failed++; $display("[TB] FAIL iso_ch0: got %h expected 0000", v); end
        bus_read(5, 4'h0, d);
        tests_run++;
        if (d !== 8'h00) begin tests_failed++; $display("[TB] FAIL ch5_cnt: got %h expected 00", d); end
        bus_read(5, 4'h8, d);
        tests_run++;
        if (d !== 8'h00) begin tests_failed++; $display("[TB] FAIL ch5_ctrl: got %h expected 00", d); end
    endtask

    task automatic test_bus();
        logic [7:0] d;
        addr = {4'd1, 4'h8}; cs = 1'b1; rd = 1'b1;
        @(posedge clk);
        #1 d = rdata;
        tests_run++;
        if (d !== 8'h05) begin tests_failed++; $display("[TB] FAIL ctrl_read: got %h expected 05", d); end
        @(negedge clk);
        addr = {4'd0, 4'h8}; wdata = 8'h09; wr = 1'b1;
        @(posedge clk);
        #1 d = rdata;
        tests_run++;
        if (d !== 8'h00) begin tests_failed++; $display("[TB] FAIL rd_wr_rdata: got %h expected 00", d); end
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        m_en[0] = 1'b1; m_irq_en[0] = 1'b0; m_wrap[0] = 1'b0; m_count[0] = 0;
        bus_read(0, 4'h8, d);
        tests_run++;
        if (d !== 8'h01) begin tests_failed++; $display("[TB] FAIL clr_reads0: got %h expected 01", d); end
        @(posedge clk);
        #1 d = rdata;
        tests_run++;
        if (d !== 8'h00) begin tests_failed++; $display("[TB] FAIL rdata_return: got %h expected 00", d); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic [7:0]  d, cv;
        int          ch, r, lim;
        for (int round = 0; round < 4; round++) begin
            for (int c = 0; c < 2; c++) begin
                cv = 8'h08;
                cv[0] = ($urandom % 4) != 0;
                cv[2] = $urandom % 2;
                lim = ($urandom % 2) ? int'($urandom_range(1, 6)) : 0;
                wr_ctrl(c, cv);
                wr_limit(c, lim);
                wr_status(c, 8'h03);
            end
            for (int s = 0; s < 30; s++) begin
                ch = $urandom % 2;
                r = $urandom % 8;
                move(ch, (r == 0) ? 2 : (r < 4) ? -1 : 1, int'($urandom_range(4, 7)));
            end
            settle();
            for (int c = 0; c < 2; c++) begin
                read_cnt(c, v);
                tests_run++;
                if (v !== 16'(m_count[c])) begin
                    tests_failed++; $display("[TB] FAIL rand_count r%0d ch%0d: got %h expected %h", round, c, v, 16'(m_count[c]));
                end
                bus_read(c, 4'h9, d);
                tests_run++;
                if (d !== exp_status(c)) begin
                    tests_failed++; $display("[TB] FAIL rand_status r%0d ch%0d: got %h expected %h", round, c, d, exp_status(c));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic [3:0] offs [4];
        offs = '{4'h0, 4'h4, 4'h8, 4'h9};
        wr_status(1, 8'h03);
        wr_ctrl(0, 8'h0B);
        wr_limit(0, 1);
        wr_status(0, 8'h03);
        move(0, 1, 5);
        settle();
        tests_run++;
        if (irq !== 1'b1 || irq !== exp_irq()) begin tests_failed++; $display("[TB] FAIL pre_reset_irq: got %b expected 1", irq); end
        pos[0] = (pos[0] + 1) & 3; drive_enc(0);
        @(negedge clk);
        addr = {4'd0, 4'h9}; cs = 1'b1; rd = 1'b1;
        @(posedge clk);
        #1 d = rdata;
        tests_run++;
        if (d !== 8'h01) begin tests_failed++; $display("[TB] FAIL pre_reset_rdata: got %h expected 01", d); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (rdata !== 8'h00) begin tests_failed++; $display("[TB] FAIL async_rst_rdata: got %h expected 00", rdata); end
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_rst_irq: got %b expected 0", irq); end
        cs = 1'b0; rd = 1'b0; enc_a = 2'b00; enc_b = 2'b00;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        settle();
        for (int i = 0; i < 4; i++) begin
            bus_read(0, offs[i], d);
            tests_run++;
            if (d !== 8'h00) begin tests_failed++; $display("[TB] FAIL post_reset ch0 off%h: got %h expected 00", offs[i], d); end
        end
        bus_read(1, 4'h0, d);
        tests_run++;
        if (d !== 8'h00) begin tests_failed++; $display("[TB] FAIL post_reset ch1 cnt: got %h expected 00", d); end
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_reset_irq: got %b expected 0", irq); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        clk = 1'b0; rst_n = 1'b0;
        cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 8'h00; wdata = 8'h00;
        enc_a = 2'b00; enc_b = 2'b00;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_up_count();
        test_glitch();
        test_sat_wrap();
        test_limit_done();
        test_illegal_snapshot();
        test_isolation();
        test_bus();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
